answer_checker: RTL and testbench

- Downstream consumer of the stage test-data generator: takes the per-stage 2-bit symbols data1..data3 and the stage1..stage3 levels.
- Replays the active symbol sequence to the display, then collects player key presses and compares them symbol by symbol.
- Emits a one-cycle pass/fail pulse per round and keeps a running score for the game controller.

---
 rtl/answer_pkg.sv | 29 ++
 rtl/answer_timer.sv | 25 ++
 rtl/answer_checker.sv | 229 ++++++++++++++++++++++
 tb/tb_answer_checker.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/answer_pkg.sv
// answer_pkg: shared types and helpers for the answer checker.
package answer_pkg;

  // Round sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHOW,
    GAP,
    WAIT_KEY,
    PASS,
    FAIL
  } state_t;

  // One displayed or pressed symbol.
  typedef logic [1:0] sym_t;

  // The score saturates here.
  localparam logic [3:0] SCORE_MAX = 4'd15;

  // Round length from the stage levels; the highest active stage wins.
  function automatic logic [1:0] round_len(input logic s1, input logic s2, input logic s3);
    if (s3)      return 2'd3;
    else if (s2) return 2'd2;
    else if (s1) return 2'd1;
    else         return 2'd0;
  endfunction

endpackage

// File: rtl/answer_timer.sv
// answer_timer: loadable 8-bit down-counter. zero_o is high while the count
// is zero, so a load of N-1 gives an N-cycle dwell.
module answer_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       en_i,
  output logic       zero_o
);

  logic [7:0] count_q;

  // Load has priority over counting; the count parks at zero until reloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rst_n)                        count_q <= 8'd0;
    else if (load_i)                   count_q <= load_val_i;
    else if (en_i && count_q != 8'd0)  count_q <= count_q - 8'd1;
  end

  assign zero_o = (count_q == 8'd0);

endmodule

// File: rtl/answer_checker.sv
// answer_checker: snapshots the active stage symbols, replays them on
// show_sym, then compares the player's keys and scores the round.
// Optional build macro ANSWER_TIMEOUT_EN: a round fails when no key arrives
// within TIMEOUT_CYCLES while waiting for an answer.
module answer_checker
  import answer_pkg::*;
#(
  parameter int SHOW_CYCLES    = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rstgame,
  input  logic       stage1,
  input  logic       stage2,
  input  logic       stage3,
  input  logic [1:0] data1,
  input  logic [1:0] data2,
  input  logic [1:0] data3,
  input  logic       key_valid,
  input  logic [1:0] key_code,
  output logic       show_valid,
  output logic [1:0] show_sym,
  output logic       busy,
  output logic       pass,
  output logic       fail,
  output logic [3:0] score
);

  // Dwell and timeout counters are 8 bits wide; zero would wrap to 256.
  if (SHOW_CYCLES < 1 || SHOW_CYCLES > 255 || GAP_CYCLES < 1 || GAP_CYCLES > 255 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $fatal(1, "answer_checker: cycle parameters must be in 1..255");
  end

  localparam logic [7:0] SHOW_LOAD = 8'(SHOW_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);
`ifdef ANSWER_TIMEOUT_EN
  localparam logic [7:0] WAIT_LOAD = 8'(TIMEOUT_CYCLES - 1);
`endif

  state_t     state_q;
  logic [1:0] lvl;
  logic [1:0] lvl_done_q;
  logic [1:0] len_q;
  logic [1:0] idx_q;
  sym_t       seq_q [0:2];
  logic       show_valid_q;
  sym_t       show_sym_q;
  logic       busy_q;
  logic       pass_q;
  logic       fail_q;
  logic [3:0] score_q;

  logic       tmr_load;
  logic       tmr_en;
  logic       tmr_zero;
  logic [7:0] tmr_val;

  assign lvl = round_len(stage1, stage2, stage3);

  // Timer control: arm the next dwell on each phase change, count otherwise.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    tmr_val  = 8'd0;
    case (state_q)
      LOAD: begin
        tmr_load = 1'b1;
        tmr_val  = SHOW_LOAD;
      end
      SHOW: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      GAP: begin
        if (tmr_zero) begin
          if (idx_q < len_q - 2'd1) begin
            tmr_load = 1'b1;
            tmr_val  = SHOW_LOAD;
          end
`ifdef ANSWER_TIMEOUT_EN
          else begin
            tmr_load = 1'b1;
            tmr_val  = WAIT_LOAD;
          end
`endif
        end else begin
          tmr_en = 1'b1;
        end
      end
`ifdef ANSWER_TIMEOUT_EN
      WAIT_KEY: begin
        // Each accepted key restarts the answer window.
        if (key_valid) begin
          tmr_load = 1'b1;
          tmr_val  = WAIT_LOAD;
        end else begin
          tmr_en = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  answer_timer u_timer (
    .clk        (clk),
    .rst_n      (rstgame),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  // Round FSM with registered display, busy, pulse and score outputs.
  always_ff @(posedge clk or negedge rstgame) begin
    if (!rstgame) begin
      state_q    <= IDLE;
      lvl_done_q <= 2'd0;
      len_q      <= 2'd0;
      idx_q      <= 2'd0;
      // NOTE: the three-entry sequence store is reset along with the control
      // state; it is tiny and keeps show_sym free of X after reset.
      for (int i = 0; i < 3; i++) seq_q[i] <= 2'd0;
      show_valid_q <= 1'b0;
      show_sym_q   <= 2'd0;
      busy_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      score_q      <= 4'd0;
    end else begin
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      show_valid_q <= 1'b0;
      show_sym_q   <= 2'd0;
      busy_q       <= 1'b1;
      if (state_q != IDLE && lvl == 2'd0) begin
        // Stage controller dropped every level: abandon the round silently.
        state_q    <= IDLE;
        lvl_done_q <= 2'd0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            busy_q <= 1'b0;
            if (lvl == 2'd0) begin
              lvl_done_q <= 2'd0;
            end else if (lvl > lvl_done_q) begin
              state_q <= LOAD;
              busy_q  <= 1'b1;
            end
          end
          LOAD: begin
            seq_q[0]     <= data1;
            seq_q[1]     <= data2;
            seq_q[2]     <= data3;
            len_q        <= lvl;
            lvl_done_q   <= lvl;
            idx_q        <= 2'd0;
            state_q      <= SHOW;
            show_valid_q <= 1'b1;
            show_sym_q   <= data1;
          end
          SHOW: begin
            if (tmr_zero) begin
              state_q <= GAP;
            end else begin
              show_valid_q <= 1'b1;
              show_sym_q   <= seq_q[idx_q];
            end
          end
          GAP: begin
            if (tmr_zero) begin
              if (idx_q < len_q - 2'd1) begin
                idx_q        <= idx_q + 2'd1;
                state_q      <= SHOW;
                show_valid_q <= 1'b1;
                show_sym_q   <= seq_q[idx_q + 2'd1];
              end else begin
                idx_q   <= 2'd0;
                state_q <= WAIT_KEY;
              end
            end
          end
          WAIT_KEY: begin
            if (key_valid) begin
              if (key_code != seq_q[idx_q]) begin
                state_q <= FAIL;
                fail_q  <= 1'b1;
              end else if (idx_q == len_q - 2'd1) begin
                state_q <= PASS;
                pass_q  <= 1'b1;
                if (score_q != SCORE_MAX) score_q <= score_q + 4'd1;
              end else begin
                idx_q <= idx_q + 2'd1;
              end
            end
`ifdef ANSWER_TIMEOUT_EN
            else if (tmr_zero) begin
              state_q <= FAIL;
              fail_q  <= 1'b1;
            end
`endif
          end
          default: begin
            // PASS and FAIL last one cycle.
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign show_valid = show_valid_q;
  assign show_sym   = show_sym_q;
  assign busy       = busy_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign score      = score_q;

endmodule

// File: tb/tb_answer_checker.sv
// tb_answer_checker: randomized rounds against a phase-arithmetic model of the
// answer checker, plus a few hand-computed expectations.
module tb_answer_checker;

  localparam int S   = 4;
  localparam int G   = 2;
  localparam int T   = 16;
  localparam int PER = S + G;

  logic       clk = 1'b0;
  logic       rstgame = 1'b1;
  logic       stage1 = 1'b0, stage2 = 1'b0, stage3 = 1'b0;
  logic [1:0] data1 = 2'd0, data2 = 2'd0, data3 = 2'd0;
  logic       key_valid = 1'b0;
  logic [1:0] key_code = 2'd0;
  logic       show_valid;
  logic [1:0] show_sym;
  logic       busy, pass, fail;
  logic [3:0] score;

  int checks = 0;
  int failures = 0;

  answer_checker #(.SHOW_CYCLES(S), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .rstgame    (rstgame),
    .stage1     (stage1),
    .stage2     (stage2),
    .stage3     (stage3),
    .data1      (data1),
    .data2      (data2),
    .data3      (data3),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .show_valid (show_valid),
    .show_sym   (show_sym),
    .busy       (busy),
    .pass       (pass),
    .fail       (fail),
    .score      (score)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A round is described by the cycles elapsed since its load cycle: the
  // replay window is 1 + len*PER cycles, after which keys are collected.
  bit         m_active;
  int         m_el;
  int         m_len;
  logic [1:0] m_seq [3];
  int         m_done;
  int         m_score;
  int         m_ans;
  int         m_waited;
  int         m_res;     // 0 none, 1 pass pulse, 2 fail pulse

  function automatic int model_level();
    if (stage3) return 3;
    if (stage2) return 2;
    if (stage1) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    int lv;
    lv = model_level();
    if (!rstgame) begin
      m_active = 0; m_el = 0; m_len = 0; m_done = 0; m_score = 0;
      m_ans = 0; m_waited = 0; m_res = 0;
      for (int i = 0; i < 3; i++) m_seq[i] = 2'd0;
    end else if (m_res != 0) begin
      m_res = 0;
      if (lv == 0) m_done = 0;
    end else if (!m_active) begin
      if (lv == 0) m_done = 0;
      else if (lv > m_done) begin m_active = 1; m_el = 0; end
    end else if (lv == 0) begin
      m_active = 0; m_done = 0;
    end else if (m_el == 0) begin
      m_seq[0] = data1; m_seq[1] = data2; m_seq[2] = data3;
      m_len = lv; m_done = lv; m_el = 1;
    end else if (m_el < 1 + m_len * PER) begin
      m_el++;
      if (m_el == 1 + m_len * PER) begin m_ans = 0; m_waited = 0; end
    end else if (key_valid) begin
      if (key_code != m_seq[m_ans]) begin
        m_res = 2; m_active = 0;
      end else if (m_ans == m_len - 1) begin
        m_res = 1; m_active = 0;
        if (m_score < 15) m_score++;
      end else begin
        m_ans++; m_waited = 0;
      end
    end else begin
      m_waited++;
`ifdef ANSWER_TIMEOUT_EN
      if (m_waited == T) begin m_res = 2; m_active = 0; end
`endif
    end
  end

  // Compare every cycle, 1 time unit after the active edge.
  always @(posedge clk) begin
    logic       e_show;
    logic [1:0] e_sym;
    int         k;
    #1;
    e_show = 1'b0;
    e_sym  = 2'd0;
    if (m_active && m_el >= 1 && m_el < 1 + m_len * PER) begin
      k = m_el - 1;
      if (k % PER < S) begin e_show = 1'b1; e_sym = m_seq[k / PER]; end
    end
    check("show_valid", 8'(show_valid), 8'(e_show));
    check("show_sym", 8'(show_sym), 8'(e_sym));
    check("busy", 8'(busy), 8'(m_active || m_res != 0));
    check("pass", 8'(pass), 8'(m_res == 1));
    check("fail", 8'(fail), 8'(m_res == 2));
    check("score", 8'(score), 8'(m_score));
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_level(input int l);
    stage3 = (l == 3);
    stage2 = (l == 2) || (l == 3 && $urandom_range(0, 1) == 1);
    stage1 = (l == 1) || (l > 1 && $urandom_range(0, 1) == 1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) cyc();
    check("idle_within_budget", 8'(busy), 8'd0);
  endtask

  // plan: 0 all correct, 1 one wrong key, 2 a missing key, 3 abort mid-round.
  task automatic play_round(input int l, input int plan, input bit noise);
    logic [1:0] sq [3];
    int abort_at, bad_at, gap;
    sq[0] = data1; sq[1] = data2; sq[2] = data3;
    abort_at = $urandom_range(1, 2 + l * PER);
    bad_at   = $urandom_range(0, l - 1);
    set_level(l);
    for (int i = 0; i < 2 + l * PER; i++) begin
      cyc();
      key_valid = 1'b0;
      if (plan == 3 && i + 1 == abort_at) begin
        set_level(0);
        cyc();
        wait_idle(4);
        return;
      end
      if (noise && i >= 1 && i < 1 + l * PER) begin
        key_valid = ($urandom_range(0, 2) == 0);
        key_code  = 2'($urandom);
        data1 = 2'($urandom); data2 = 2'($urandom); data3 = 2'($urandom);
        if ($urandom_range(0, 5) == 0) set_level($urandom_range(1, 3));
      end
    end
    key_valid = 1'b0;
    set_level(l);
    for (int p = 0; p < l; p++) begin
      if (plan == 2 && p == bad_at) begin
        repeat (T + 3) cyc();
`ifdef ANSWER_TIMEOUT_EN
        break;
`endif
      end
      gap = $urandom_range(0, 3);
      if ($urandom_range(0, 5) == 0) gap = T - 1;
      repeat (gap) cyc();
      key_valid = 1'b1;
      key_code  = (plan == 1 && p == bad_at) ? sq[p] ^ 2'($urandom_range(1, 3)) : sq[p];
      cyc();
      key_valid = 1'b0;
      if (plan == 1 && p == bad_at) break;
    end
    wait_idle(40);
  endtask

  initial begin
    #1 rstgame = 1'b0;
    repeat (3) cyc();
    check("reset_busy", 8'(busy), 8'd0);
    check("reset_score", 8'(score), 8'd0);
    check("reset_show", 8'(show_valid), 8'd0);
    rstgame = 1'b1;
    cyc();

    // Directed stage-1 round, symbol 2, checked against literal timing.
    data1 = 2'd2;
    set_level(1);
    cyc();
    check("lit_load_busy", 8'(busy), 8'd1);
    check("lit_load_noshow", 8'(show_valid), 8'd0);
    cyc();
    check("lit_first_show", 8'(show_valid), 8'd1);
    check("lit_first_sym", 8'(show_sym), 8'd2);
    repeat (3) cyc();
    check("lit_last_show", 8'(show_valid), 8'd1);
    cyc();
    check("lit_gap", 8'(show_valid), 8'd0);
    repeat (2) cyc();
    key_valid = 1'b1; key_code = 2'd2;
    cyc();
    key_valid = 1'b0;
    check("lit_pass", 8'(pass), 8'd1);
    check("lit_score1", 8'(score), 8'd1);
    cyc();
    check("lit_idle", 8'(busy), 8'd0);

    // Randomized rounds.
    for (int r = 0; r < 120; r++) begin
      int l, sel, plan;
      if (r == 60) begin rstgame = 1'b0; cyc(); rstgame = 1'b1; end
      set_level(0);
      repeat ($urandom_range(1, 2)) cyc();
      data1 = 2'($urandom); data2 = 2'($urandom); data3 = 2'($urandom);
      l    = $urandom_range(1, 3);
      sel  = $urandom_range(0, 9);
      plan = (sel < 5) ? 0 : (sel < 7) ? 1 : (sel < 9) ? 2 : 3;
      play_round(l, plan, 1'($urandom_range(0, 1)));
      if (plan == 0 && l < 3 && $urandom_range(0, 1) == 1) begin
        data1 = 2'($urandom); data2 = 2'($urandom); data3 = 2'($urandom);
        play_round($urandom_range(l + 1, 3), 0, 1'b0);
      end
    end

    // Sixteen straight passes must saturate the score.
    for (int r = 0; r < 16; r++) begin
      set_level(0);
      cyc();
      data1 = 2'($urandom);
      play_round(1, 0, 1'b0);
    end
    check("lit_score_saturated", 8'(score), 8'd15);

    set_level(0);
    repeat (3) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule
